// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and defaults for the parking gate controller
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN_IN  = 2'd1,
    OPEN_OUT = 2'd2,
    CLOSING  = 2'd3
  } state_t;

  localparam logic DIR_IN  = 1'b0;
  localparam logic DIR_OUT = 1'b1;

  localparam int DEF_CAPACITY       = 16;
  localparam int DEF_CNT_W          = 5;
  localparam int DEF_TIMEOUT_CYCLES = 32;
  localparam int DEF_CLOSE_CYCLES   = 4;

endpackage

// File: rtl/parking_occupancy_cnt.sv
// rtl/parking_occupancy_cnt.sv - saturating up/down occupancy counter with full/empty flags
module parking_occupancy_cnt
  import parking_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CAPACITY = DEF_CAPACITY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  assign full  = (count == CNT_W'(CAPACITY));
  assign empty = (count == '0);

  // Simultaneous inc and dec cancel; each direction clamps at its bound.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + 1'b1;
    end else if (dec && !inc && !empty) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// rtl/parking_gate_ctrl.sv - single-lane barrier arbiter with open/timeout/close sequencing
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY       = DEF_CAPACITY,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CLOSE_CYCLES   = DEF_CLOSE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             entry_req,
  input  logic             exit_req,
  input  logic             entering,
  input  logic             exiting,
  output logic             gate_open,
  output logic             entry_grant,
  output logic             exit_grant,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             timeout_err
);

  // One timer serves both the open-wait and the closing guard.
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] CLS_LAST = TW'(CLOSE_CYCLES - 1);

  state_t        state, state_nx;
  logic [TW-1:0] timer, timer_nx;
  logic          last_dir, last_dir_nx;
  logic          tmo_nx;
  logic          elig_in, elig_out;

  // Occupancy follows the sensors regardless of which side holds the gate.
  parking_occupancy_cnt #(
    .CNT_W    (CNT_W),
    .CAPACITY (CAPACITY)
  ) u_occ (
    .clk   (clk),
    .rst   (rst),
    .inc   (entering),
    .dec   (exiting),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign elig_in  = entry_req && !full;
  assign elig_out = exit_req && !empty;

  // State, timer, round-robin memory and the timeout pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      timer       <= '0;
      last_dir    <= DIR_OUT;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      last_dir    <= last_dir_nx;
      timeout_err <= tmo_nx;
    end
  end

  // Arbitration and sequencing; a passage pulse takes priority over the timeout.
  always_comb begin
    state_nx    = state;
    timer_nx    = timer;
    last_dir_nx = last_dir;
    tmo_nx      = 1'b0;
    case (state)
      IDLE: begin
        timer_nx = '0;
        if (elig_in && (!elig_out || last_dir == DIR_OUT)) begin
          state_nx    = OPEN_IN;
          last_dir_nx = DIR_IN;
        end else if (elig_out) begin
          state_nx    = OPEN_OUT;
          last_dir_nx = DIR_OUT;
        end
      end
      OPEN_IN, OPEN_OUT: begin
        if ((state == OPEN_IN) ? entering : exiting) begin
          state_nx = CLOSING;
          timer_nx = '0;
        end else if (timer == TMO_LAST) begin
          state_nx = CLOSING;
          timer_nx = '0;
          tmo_nx   = 1'b1;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      CLOSING: begin
        if (timer == CLS_LAST) begin
          state_nx = IDLE;
          timer_nx = '0;
        end else begin
          timer_nx = timer + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        timer_nx = '0;
      end
    endcase
  end

  // Gate and grant commands decode the state directly.
  always_comb begin
    gate_open   = 1'b0;
    entry_grant = 1'b0;
    exit_grant  = 1'b0;
    case (state)
      OPEN_IN: begin
        gate_open   = 1'b1;
        entry_grant = 1'b1;
      end
      OPEN_OUT: begin
        gate_open  = 1'b1;
        exit_grant = 1'b1;
      end
      default: begin
        gate_open   = 1'b0;
        entry_grant = 1'b0;
        exit_grant  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb/tb_parking_gate_ctrl.sv - self-checking bench for parking_gate_ctrl
module tb_parking_gate_ctrl;

  localparam int CAP = 16;
  localparam int TMO = 32;
  localparam int CLS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       entry_req = 1'b0;
  logic       exit_req = 1'b0;
  logic       entering = 1'b0;
  logic       exiting = 1'b0;
  logic       gate_open, entry_grant, exit_grant, full, empty, timeout_err;
  logic [4:0] count;

  int total = 0;
  int bad = 0;

  parking_gate_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .entry_req   (entry_req),
    .exit_req    (exit_req),
    .entering    (entering),
    .exiting     (exiting),
    .gate_open   (gate_open),
    .entry_grant (entry_grant),
    .exit_grant  (exit_grant),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // Model: which side holds the gate (0 none, 1 in, 2 out), how long it has
  // been open, closed cycles still owed, who went last, and the occupancy.
  int m_cnt = 0;
  int m_dir = 0;
  int m_age = 0;
  int m_close = 0;
  bit m_last_in = 1'b0;
  bit m_tmo = 1'b0;
  bit m_full, m_empty, m_ein, m_eout;
  int m_pick;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_dir = 0; m_age = 0; m_close = 0; m_last_in = 1'b0; m_tmo = 1'b0;
    end else begin
      m_full  = (m_cnt == CAP);
      m_empty = (m_cnt == 0);
      m_tmo   = 1'b0;
      if (m_dir != 0) begin
        if ((m_dir == 1 && entering) || (m_dir == 2 && exiting)) begin
          m_dir = 0; m_close = CLS;
        end else if (m_age == TMO - 1) begin
          m_dir = 0; m_close = CLS; m_tmo = 1'b1;
        end else begin
          m_age++;
        end
      end else if (m_close > 0) begin
        m_close--;
      end else begin
        m_ein  = entry_req && !m_full;
        m_eout = exit_req && !m_empty;
        if (m_ein && m_eout) m_pick = m_last_in ? 2 : 1;
        else if (m_ein)      m_pick = 1;
        else if (m_eout)     m_pick = 2;
        else                 m_pick = 0;
        if (m_pick != 0) begin
          m_dir = m_pick; m_age = 0; m_last_in = (m_pick == 1);
        end
      end
      if (entering && !exiting && m_cnt < CAP) m_cnt++;
      else if (exiting && !entering && m_cnt > 0) m_cnt--;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if (gate_open !== (m_dir != 0) || entry_grant !== (m_dir == 1) ||
          exit_grant !== (m_dir == 2) || int'(count) != m_cnt ||
          full !== (m_cnt == CAP) || empty !== (m_cnt == 0) || timeout_err !== m_tmo) begin
        bad++;
        $display("FAIL cycle_model t=%0t got gate=%b in=%b out=%b cnt=%0d full=%b empty=%b tmo=%b want gate=%b in=%b out=%b cnt=%0d full=%b empty=%b tmo=%b",
                 $time, gate_open, entry_grant, exit_grant, count, full, empty, timeout_err,
                 (m_dir != 0), (m_dir == 1), (m_dir == 2), m_cnt, (m_cnt == CAP), (m_cnt == 0), m_tmo);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, got, want, $time);
    end
  endtask

  task automatic pulse(input bit e, input bit x, input int n);
    entering = e;
    exiting  = x;
    repeat (n) @(negedge clk);
    entering = 1'b0;
    exiting  = 1'b0;
  endtask

  task automatic wait_grant(input string name, output int n);
    n = 0;
    while (!gate_open && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, int'(gate_open), 1);
  endtask

  int n;
  int want_dir[3] = '{1, 2, 1};

  initial begin
    #3;
    check("rst_gate", int'(gate_open), 0);
    check("rst_entry_grant", int'(entry_grant), 0);
    check("rst_exit_grant", int'(exit_grant), 0);
    check("rst_count", int'(count), 0);
    check("rst_full", int'(full), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_tmo", int'(timeout_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic entry, with the request withdrawn while the grant is held.
    entry_req = 1'b1;
    @(negedge clk);
    check("basic_gate", int'(gate_open), 1);
    check("basic_entry_grant", int'(entry_grant), 1);
    entry_req = 1'b0;
    repeat (2) @(negedge clk);
    check("basic_held", int'(entry_grant), 1);
    pulse(1'b1, 1'b0, 1);
    check("basic_count", int'(count), 1);
    check("basic_closed", int'(gate_open), 0);
    entry_req = 1'b1;
    wait_grant("regrant_wait", n);
    check("closed_samples", n, CLS + 1);
    pulse(1'b1, 1'b0, 1);
    entry_req = 1'b0;
    check("second_count", int'(count), 2);

    // Timeout with no passage.
    entry_req = 1'b1;
    wait_grant("tmo_grant_wait", n);
    entry_req = 1'b0;
    n = 0;
    while (gate_open && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("tmo_open_cycles", n, TMO);
    check("tmo_pulse", int'(timeout_err), 1);
    check("tmo_count", int'(count), 2);
    @(negedge clk);
    check("tmo_once", int'(timeout_err), 0);

    // Passage on the last open cycle beats the timeout.
    entry_req = 1'b1;
    wait_grant("edge_grant_wait", n);
    entry_req = 1'b0;
    repeat (TMO - 1) @(negedge clk);
    check("edge_still_open", int'(gate_open), 1);
    pulse(1'b1, 1'b0, 1);
    check("edge_closed", int'(gate_open), 0);
    check("edge_no_tmo", int'(timeout_err), 0);
    check("edge_count", int'(count), 3);

    // Fill past capacity with stray pulses; inbound refused, outbound granted.
    pulse(1'b1, 1'b0, 20);
    check("fill_count", int'(count), CAP);
    check("fill_full", int'(full), 1);
    entry_req = 1'b1;
    repeat (10) @(negedge clk);
    check("full_no_grant", int'(gate_open), 0);
    exit_req = 1'b1;
    wait_grant("full_exit_wait", n);
    check("full_exit_grant", int'(exit_grant), 1);
    entry_req = 1'b0;
    exit_req  = 1'b0;
    pulse(1'b0, 1'b1, 1);
    check("after_exit_count", int'(count), CAP - 1);

    // Both sides requesting: round-robin IN, OUT, IN.
    pulse(1'b0, 1'b1, 10);
    check("rr_start_count", int'(count), 5);
    entry_req = 1'b1;
    exit_req  = 1'b1;
    for (int r = 0; r < 3; r++) begin
      wait_grant("rr_wait", n);
      check("rr_dir", entry_grant ? 1 : (exit_grant ? 2 : 0), want_dir[r]);
      if (entry_grant) pulse(1'b1, 1'b0, 1);
      else             pulse(1'b0, 1'b1, 1);
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
    check("rr_end_count", int'(count), 6);

    // Saturation at zero and simultaneous pulses.
    pulse(1'b0, 1'b1, 6);
    check("drain_empty", int'(empty), 1);
    pulse(1'b0, 1'b1, 1);
    check("sat_zero", int'(count), 0);
    pulse(1'b1, 1'b0, 3);
    pulse(1'b1, 1'b1, 1);
    check("both_same", int'(count), 3);

    // Asynchronous reset while the outbound side holds the gate.
    exit_req = 1'b1;
    wait_grant("mid_wait", n);
    check("mid_exit_grant", int'(exit_grant), 1);
    #2 rst = 1'b1;
    #1;
    check("mid_gate", int'(gate_open), 0);
    check("mid_exit_grant_rst", int'(exit_grant), 0);
    check("mid_count", int'(count), 0);
    check("mid_empty", int'(empty), 1);
    exit_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
